// File: rtl/zacore_mem_arbiter.sv
// Purpose : shares one memory bus between fetch and the data stage; data has priority,
//           bounded by a streak limit so fetch cannot starve; flush drops in-flight fetch data.
// Latency : request->bus same cycle, bus_rsp->x_rsp same cycle; backpressure: bus_req_ready
//           stalls the owner, one transaction outstanding, loser waits with valid held.
//
// Ports   : clk/rst_n (synchronous, active-low), flush,
//           if_req_* / if_rsp_*  fetch side, dm_req_* / dm_rsp_*  data side,
//           bus_req_* / bus_rsp_* external bus.
// Option  : define ZACORE_ARB_PERF_EN to add perf_if_grants, perf_dm_grants,
//           perf_stall_cycles (PERF_CNT_W bits each, wrapping).
module zacore_mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned PERF_CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        if_req_valid,
    input  logic [29:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        dm_req_valid,
    input  logic [29:0] dm_req_addr,
    input  logic        dm_req_we,
    input  logic [3:0]  dm_req_be,
    input  logic [31:0] dm_req_wdata,
    output logic        dm_req_ready,
    output logic        dm_rsp_valid,
    output logic [31:0] dm_rsp_rdata,
    output logic        bus_req_valid,
    output logic [29:0] bus_req_addr,
    output logic        bus_req_we,
    output logic [3:0]  bus_req_be,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_req_ready,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_data
`ifdef ZACORE_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_if_grants,
    output logic [PERF_CNT_W-1:0] perf_dm_grants,
    output logic [PERF_CNT_W-1:0] perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t     state_q, state_d;
    logic       owner_dm_q, owner_dm_d;   // 1 = data stage owns the bus, 0 = fetch
    logic       drop_q, drop_d;           // pending fetch response must be swallowed
    logic [3:0] streak_q, streak_d;

    logic grant_dm;     // requester driving the bus this cycle
    logic req_vld;      // internal bus_req_valid before reset gating
    logic rsp_hit;      // response that belongs to the owned transaction
    logic acc;
    logic if_acc;
    logic dm_acc;

    // Next state, arbitration and drop tracking.
    always_comb begin
        state_d    = state_q;
        owner_dm_d = owner_dm_q;
        drop_d     = drop_q;
        grant_dm   = owner_dm_q;
        req_vld    = 1'b0;
        rsp_hit    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Data wins unless it has used up its streak while fetch is waiting.
                grant_dm = dm_req_valid && !((streak_q == STREAK_MAX) && if_req_valid);
                req_vld  = if_req_valid | dm_req_valid;
                if (req_vld) begin
                    owner_dm_d = grant_dm;
                    state_d    = bus_req_ready ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                // Requests are never retracted; a flushed fetch still completes on the bus.
                req_vld = 1'b1;
                if (!owner_dm_q && flush) drop_d = 1'b1;
                if (bus_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus_rsp_valid) begin
                    rsp_hit = 1'b1;
                    drop_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (!owner_dm_q && flush) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc    = req_vld & bus_req_ready;
    assign if_acc = acc & ~grant_dm;
    assign dm_acc = acc & grant_dm;

    // Streak only counts data grants that actually made fetch wait.
    always_comb begin
        streak_d = streak_q;
        if (!if_req_valid || if_acc) begin
            streak_d = 4'd0;
        end else if (dm_acc && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_dm_q <= 1'b0;
            drop_q     <= 1'b0;
            streak_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            drop_q     <= drop_d;
            streak_q   <= streak_d;
        end
    end

    // Outputs are held at zero for the whole reset window, whatever state was left behind.
    always_comb begin
        if_req_ready  = 1'b0;
        dm_req_ready  = 1'b0;
        if_rsp_valid  = 1'b0;
        if_rsp_data   = 32'd0;
        dm_rsp_valid  = 1'b0;
        dm_rsp_rdata  = 32'd0;
        bus_req_valid = 1'b0;
        bus_req_addr  = 30'd0;
        bus_req_we    = 1'b0;
        bus_req_be    = 4'd0;
        bus_req_wdata = 32'd0;
        if (rst_n) begin
            if_req_ready  = if_acc;
            dm_req_ready  = dm_acc;
            bus_req_valid = req_vld;
            if (req_vld) begin
                if (grant_dm) begin
                    bus_req_addr  = dm_req_addr;
                    bus_req_we    = dm_req_we;
                    bus_req_be    = dm_req_be;
                    bus_req_wdata = dm_req_wdata;
                end else begin
                    bus_req_addr  = if_req_addr;
                    bus_req_be    = 4'hF;
                end
            end
            if (rsp_hit) begin
                // A flush in the response cycle itself also kills the instruction.
                if (owner_dm_q) begin
                    dm_rsp_valid = 1'b1;
                    dm_rsp_rdata = bus_rsp_data;
                end else if (!drop_q && !flush) begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = bus_rsp_data;
                end
            end
        end
    end

`ifdef ZACORE_ARB_PERF_EN
    logic stall;
    assign stall = (if_req_valid | dm_req_valid) & ~acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_if_grants    <= '0;
            perf_dm_grants    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (if_acc) perf_if_grants    <= perf_if_grants + 1'b1;
            if (dm_acc) perf_dm_grants    <= perf_dm_grants + 1'b1;
            if (stall)  perf_stall_cycles <= perf_stall_cycles + 1'b1;
        end
    end
`else
    // Counter width only matters in the perf build.
    if (PERF_CNT_W == 0) begin : g_no_perf
    end
`endif

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
module tb_zacore_mem_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        if_req_valid;
    logic [29:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid;
    logic [29:0] dm_req_addr;
    logic        dm_req_we;
    logic [3:0]  dm_req_be;
    logic [31:0] dm_req_wdata;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        bus_req_valid;
    logic [29:0] bus_req_addr;
    logic        bus_req_we;
    logic [3:0]  bus_req_be;
    logic [31:0] bus_req_wdata;
    logic        bus_req_ready;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    zacore_mem_arbiter #(.MAX_DATA_STREAK(MAX), .PERF_CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_we(dm_req_we),
        .dm_req_be(dm_req_be), .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
        .bus_req_valid(bus_req_valid), .bus_req_addr(bus_req_addr), .bus_req_we(bus_req_we),
        .bus_req_be(bus_req_be), .bus_req_wdata(bus_req_wdata), .bus_req_ready(bus_req_ready),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        flush = 0; if_req_valid = 0; if_req_addr = '0;
        dm_req_valid = 0; dm_req_addr = '0; dm_req_we = 0; dm_req_be = '0; dm_req_wdata = '0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_data = '0;
    endtask

    // Random-phase reference: transaction-level view of the shared bus.
    logic        r_if_v, r_dm_v, r_dm_we;
    logic [29:0] r_if_a, r_dm_a;
    logic [3:0]  r_dm_be;
    logic [31:0] r_dm_wd;
    bit          m_open, m_sent, m_dm, m_drop;
    int          m_run, rsp_wait;
    bit          e_vld, e_dm, e_acc, e_rsp, e_if_rsp, e_dm_rsp;

    initial begin
        quiet();
        rst_n = 0;
        // Reset with requests pending: everything must stay at zero.
        if_req_valid = 1; dm_req_valid = 1; dm_req_be = 4'hF; bus_req_ready = 1;
        tick();
        #1;
        chk("rst_bus_vld", bus_req_valid, 0);
        chk("rst_bus_be", bus_req_be, 0);
        chk("rst_if_rdy", if_req_ready, 0);
        chk("rst_dm_rdy", dm_req_ready, 0);
        quiet(); rst_n = 1;
        tick();

        // Fetch only, response two cycles after the grant.
        if_req_valid = 1; if_req_addr = 30'h10; bus_req_ready = 1; #1;
        chk("f_rdy", if_req_ready, 1);
        chk("f_addr", bus_req_addr, 30'h10);
        chk("f_be", bus_req_be, 4'hF);
        chk("f_wd", bus_req_wdata, 0);
        tick(); if_req_valid = 0; bus_req_ready = 0; #1;
        chk("f_wait_vld", bus_req_valid, 0);
        tick(); bus_rsp_valid = 1; bus_rsp_data = 32'h13; #1;
        chk("f_rsp_vld", if_rsp_valid, 1);
        chk("f_rsp_dat", if_rsp_data, 32'h13);
        chk("f_rsp_dm", dm_rsp_valid, 0);
        tick(); bus_rsp_valid = 0;

        // Simultaneous requests: data first, fetch after the data response.
        if_req_valid = 1; if_req_addr = 30'h100;
        dm_req_valid = 1; dm_req_addr = 30'h200; dm_req_be = 4'hF; bus_req_ready = 1; #1;
        chk("both_addr", bus_req_addr, 30'h200);
        chk("both_dm_rdy", dm_req_ready, 1);
        chk("both_if_rdy", if_req_ready, 0);
        tick(); dm_req_valid = 0; #1;
        chk("both_wait_vld", bus_req_valid, 0);
        tick(); bus_rsp_valid = 1; bus_rsp_data = 32'h55; #1;
        chk("both_dm_rsp", dm_rsp_valid, 1);
        chk("both_dm_dat", dm_rsp_rdata, 32'h55);
        chk("both_if_rsp", if_rsp_valid, 0);
        chk("both_no_grant", bus_req_valid, 0);
        tick(); bus_rsp_valid = 0; #1;
        chk("both_if_grant", if_req_ready, 1);
        chk("both_if_addr", bus_req_addr, 30'h100);
        tick(); if_req_valid = 0; bus_rsp_valid = 1; bus_rsp_data = 32'h77; #1;
        chk("both_if_rsp2", if_rsp_valid, 1);
        tick(); bus_rsp_valid = 0;

        // Streak limit: D,D,D,D,I repeating.
        if_req_valid = 1; if_req_addr = 30'h40;
        dm_req_valid = 1; dm_req_addr = 30'h80; bus_req_ready = 1;
        for (int g = 0; g < 10; g++) begin
            #1;
            chk($sformatf("streak_g%0d", g), {30'd0, dm_req_ready, if_req_ready},
                (g % 5 == 4) ? 32'd1 : 32'd2);
            tick(); bus_rsp_valid = 1;
            tick(); bus_rsp_valid = 0;
        end
        quiet();

        // Flush while fetch waits: response swallowed, next fetch normal.
        if_req_valid = 1; if_req_addr = 30'h20; bus_req_ready = 1; #1;
        chk("fl_rdy", if_req_ready, 1);
        tick(); if_req_valid = 0; flush = 1;
        tick(); flush = 0; bus_rsp_valid = 1; bus_rsp_data = 32'hDEADBEEF; #1;
        chk("fl_drop", if_rsp_valid, 0);
        tick(); bus_rsp_valid = 0; if_req_valid = 1; if_req_addr = 30'h24; #1;
        chk("fl_next_rdy", if_req_ready, 1);
        tick(); if_req_valid = 0; bus_rsp_valid = 1; bus_rsp_data = 32'h1234; #1;
        chk("fl_next_rsp", if_rsp_valid, 1);
        chk("fl_next_dat", if_rsp_data, 32'h1234);
        tick(); quiet();

        // Flush in REQ plus a stray response there: request completes, response dropped.
        if_req_valid = 1; if_req_addr = 30'h30; #1;
        chk("flr_vld", bus_req_valid, 1);
        tick(); flush = 1; bus_rsp_valid = 1; #1;
        chk("flr_stray", if_rsp_valid, 0);
        chk("flr_hold", bus_req_valid, 1);
        tick(); flush = 0; bus_rsp_valid = 0; bus_req_ready = 1; #1;
        chk("flr_rdy", if_req_ready, 1);
        chk("flr_addr", bus_req_addr, 30'h30);
        tick(); if_req_valid = 0; bus_req_ready = 0; bus_rsp_valid = 1; #1;
        chk("flr_drop", if_rsp_valid, 0);
        tick(); quiet();

        // Store held off by the bus for three cycles.
        dm_req_valid = 1; dm_req_addr = 30'h300; dm_req_we = 1;
        dm_req_be = 4'b0011; dm_req_wdata = 32'hA5A5;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("st_vld", bus_req_valid, 1);
            chk("st_be", bus_req_be, 4'b0011);
            chk("st_wd", bus_req_wdata, 32'hA5A5);
            chk("st_we", bus_req_we, 1);
            chk("st_rdy_lo", dm_req_ready, 0);
            tick();
        end
        bus_req_ready = 1; #1;
        chk("st_rdy", dm_req_ready, 1);
        chk("st_addr", bus_req_addr, 30'h300);
        tick(); quiet(); bus_rsp_valid = 1; #1;
        chk("st_ack", dm_rsp_valid, 1);
        tick(); quiet();

        // Reset during WAIT, late response ignored, next grant normal.
        if_req_valid = 1; if_req_addr = 30'h50; bus_req_ready = 1; #1;
        chk("rw_rdy", if_req_ready, 1);
        tick(); quiet(); rst_n = 0;
        tick(); rst_n = 1; bus_rsp_valid = 1; bus_rsp_data = 32'hBAD; #1;
        chk("rw_if_rsp", if_rsp_valid, 0);
        chk("rw_dm_rsp", dm_rsp_valid, 0);
        chk("rw_bus_vld", bus_req_valid, 0);
        tick(); bus_rsp_valid = 0; dm_req_valid = 1; dm_req_addr = 30'h60; bus_req_ready = 1; #1;
        chk("rw_dm_rdy", dm_req_ready, 1);
        chk("rw_dm_addr", bus_req_addr, 30'h60);
        tick(); quiet(); bus_rsp_valid = 1; bus_rsp_data = 32'hCAFE; #1;
        chk("rw_dm_rsp2", dm_rsp_valid, 1);
        chk("rw_dm_dat", dm_rsp_rdata, 32'hCAFE);
        tick(); quiet();

        // Random traffic against the transaction-level reference.
        r_if_v = 0; r_dm_v = 0; r_if_a = '0; r_dm_a = '0; r_dm_we = 0; r_dm_be = '0; r_dm_wd = '0;
        m_open = 0; m_sent = 0; m_dm = 0; m_drop = 0; m_run = 0; rsp_wait = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!r_if_v && $urandom_range(0, 2) == 0) begin
                r_if_v = 1; r_if_a = 30'($urandom);
            end
            if (!r_dm_v && $urandom_range(0, 1) == 0) begin
                r_dm_v = 1; r_dm_a = 30'($urandom); r_dm_we = 1'($urandom);
                r_dm_be = 4'($urandom); r_dm_wd = $urandom;
            end
            if_req_valid = r_if_v; if_req_addr = r_if_a;
            dm_req_valid = r_dm_v; dm_req_addr = r_dm_a; dm_req_we = r_dm_we;
            dm_req_be = r_dm_be; dm_req_wdata = r_dm_wd;
            bus_req_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 11) == 0);
            bus_rsp_valid = 0;
            if (m_sent && rsp_wait == 0) bus_rsp_valid = 1;
            if (!m_sent && $urandom_range(0, 31) == 0) bus_rsp_valid = 1;
            bus_rsp_data = $urandom;
            #1;
            if (!m_open) begin
                e_vld = r_if_v | r_dm_v;
                e_dm  = r_dm_v && !(m_run == MAX && r_if_v);
            end else begin
                e_vld = !m_sent;
                e_dm  = m_dm;
            end
            e_acc    = e_vld && bus_req_ready;
            e_rsp    = m_sent && bus_rsp_valid;
            e_dm_rsp = e_rsp && m_dm;
            e_if_rsp = e_rsp && !m_dm && !(m_drop || flush);
            chk("rnd_bus_vld", bus_req_valid, e_vld);
            chk("rnd_if_rdy", if_req_ready, e_acc && !e_dm);
            chk("rnd_dm_rdy", dm_req_ready, e_acc && e_dm);
            if (e_vld) begin
                chk("rnd_addr", bus_req_addr, e_dm ? r_dm_a : r_if_a);
                chk("rnd_we", bus_req_we, e_dm ? r_dm_we : 1'b0);
                chk("rnd_be", bus_req_be, e_dm ? r_dm_be : 4'hF);
                chk("rnd_wd", bus_req_wdata, e_dm ? r_dm_wd : 32'd0);
            end
            chk("rnd_if_rsp", if_rsp_valid, e_if_rsp);
            chk("rnd_dm_rsp", dm_rsp_valid, e_dm_rsp);
            if (e_if_rsp) chk("rnd_if_dat", if_rsp_data, bus_rsp_data);
            if (e_dm_rsp) chk("rnd_dm_dat", dm_rsp_rdata, bus_rsp_data);

            // Advance the reference across the clock edge.
            if (!r_if_v || (e_acc && !e_dm)) m_run = 0;
            else if (e_acc && e_dm && m_run < MAX) m_run++;
            if (m_open && !m_dm && flush) m_drop = 1;
            if (e_rsp) begin
                m_open = 0; m_sent = 0; m_drop = 0;
            end else if (!m_open && e_vld) begin
                m_open = 1; m_dm = e_dm; m_sent = e_acc;
                rsp_wait = $urandom_range(0, 3);
            end else if (m_open && !m_sent && e_acc) begin
                m_sent = 1; rsp_wait = $urandom_range(0, 3);
            end else if (m_sent && rsp_wait > 0) begin
                rsp_wait--;
            end
            if (e_acc && e_dm)  r_dm_v = 0;
            if (e_acc && !e_dm) r_if_v = 0;
            tick();
        end

        quiet();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
